// File: rtl/ro_array_axil_counter_pkg.sv
// Shared definitions for the ring-oscillator array counter: register map,
// control/status bit positions, AXI response codes and the window FSM states.
package ro_array_pkg;

  localparam int unsigned REG_CTRL    = 'h00;
  localparam int unsigned REG_WINDOW  = 'h04;
  localparam int unsigned REG_STATUS  = 'h08;
  localparam int unsigned REG_OVF     = 'h0C;
  localparam int unsigned REG_RESULT0 = 'h40;

  localparam int CTRL_START  = 0;
  localparam int CTRL_CONT   = 1;
  localparam int CTRL_ABORT  = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_LATCH
  } state_t;

endpackage

// File: rtl/ro_array_axil_counter_sat_counter.sv
// Per-channel tick counter that sticks at its ceiling and flags any tick
// that arrived while it was already full.
module ro_sat_counter
  import ro_array_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (inc) begin
      if (count == MAX) begin
        sat <= 1'b1;
      end else begin
        count <= count + ONE;
      end
    end
  end

endmodule

// File: rtl/ro_array_axil_counter.sv
// AXI4-Lite slave that counts ring-oscillator ticks per channel over a
// programmable window and publishes snapshots as read-only result registers.
module ro_array_axil_counter
  import ro_array_pkg::*;
#(
  parameter int NUM_CH             = 8,
  parameter int CNT_W              = 32,
  parameter int WIN_W              = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [NUM_CH-1:0]               ro_tick,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            irq
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;

  state_t                  state, state_next;
  logic [WIN_W-1:0]        window, win_cnt;
  logic                    cont, irq_en, done, busy;
  logic [15:0]             seq;
  logic [NUM_CH-1:0]       sat, ovf;
  logic [CNT_W-1:0]        count  [NUM_CH];
  logic [CNT_W-1:0]        result [NUM_CH];
  logic                    load, latch_en, counting;
  logic [AW-1:0]           wr_word, rd_word;
  logic                    wr_en, wr_ok, rd_en, rd_hit, aw_go, ar_go;
  logic                    start_req, abort_req, done_clr;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_data;
  logic                    unused_ok;

  assign wr_word   = {S_AXI_AWADDR[AW-1:2], 2'b00};
  assign rd_word   = {S_AXI_ARADDR[AW-1:2], 2'b00};
  assign wr_en     = S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en     = S_AXI_ARREADY & S_AXI_ARVALID;
  assign aw_go     = !S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID;
  assign ar_go     = !S_AXI_ARREADY && S_AXI_ARVALID && !S_AXI_RVALID;
  assign wr_ok     = (wr_word == AW'(REG_CTRL)) || (wr_word == AW'(REG_WINDOW)) ||
                     (wr_word == AW'(REG_STATUS));
  assign start_req = wr_en && (wr_word == AW'(REG_CTRL)) && S_AXI_WSTRB[0] && S_AXI_WDATA[CTRL_START];
  assign abort_req = wr_en && (wr_word == AW'(REG_CTRL)) && S_AXI_WSTRB[0] && S_AXI_WDATA[CTRL_ABORT];
  assign done_clr  = wr_en && (wr_word == AW'(REG_STATUS)) && S_AXI_WSTRB[0] && S_AXI_WDATA[STATUS_DONE];
  assign busy      = (state != ST_IDLE);
  assign irq       = done & irq_en;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Abort beats everything, including a start in the same write.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    latch_en   = 1'b0;
    counting   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!abort_req && start_req) begin
          state_next = ST_COUNT;
          load       = 1'b1;
        end
      end
      ST_COUNT: begin
        if (abort_req) begin
          state_next = ST_IDLE;
        end else begin
          counting = 1'b1;
          if (win_cnt == WIN_W'(1)) state_next = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (abort_req) begin
          state_next = ST_IDLE;
        end else begin
          latch_en = 1'b1;
          if (cont) begin
            state_next = ST_COUNT;
            load       = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      win_cnt <= '0;
    end else if (load) begin
      win_cnt <= (window == '0) ? WIN_W'(1) : window;
    end else if (state == ST_COUNT) begin
      win_cnt <= win_cnt - WIN_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ro_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (ACLK),
      .rst_n (ARESETN),
      .clear (load),
      .inc   (counting & ro_tick[i]),
      .count (count[i]),
      .sat   (sat[i])
    );
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_CH; i++) result[i] <= '0;
      ovf <= '0;
      seq <= '0;
    end else if (latch_en) begin
      for (int i = 0; i < NUM_CH; i++) result[i] <= count[i];
      ovf <= sat;
      seq <= seq + 16'd1;
    end
  end

  // A snapshot landing in the same cycle as a W1C keeps done set.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      done   <= 1'b0;
      cont   <= 1'b0;
      irq_en <= 1'b0;
      window <= '0;
    end else begin
      if (latch_en)      done <= 1'b1;
      else if (done_clr) done <= 1'b0;
      if (wr_en && (wr_word == AW'(REG_CTRL)) && S_AXI_WSTRB[0]) begin
        cont   <= S_AXI_WDATA[CTRL_CONT];
        irq_en <= S_AXI_WDATA[CTRL_IRQ_EN];
      end
      if (wr_en && (wr_word == AW'(REG_WINDOW))) begin
        for (int b = 0; b < WIN_W; b++) begin
          if (S_AXI_WSTRB[b/8]) window[b] <= S_AXI_WDATA[b];
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
    end else begin
      S_AXI_AWREADY <= aw_go;
      S_AXI_WREADY  <= aw_go;
      if (wr_en) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b1;
    if (rd_word == AW'(REG_CTRL)) begin
      rd_data[CTRL_CONT]   = cont;
      rd_data[CTRL_IRQ_EN] = irq_en;
    end else if (rd_word == AW'(REG_WINDOW)) begin
      rd_data = 32'(window);
    end else if (rd_word == AW'(REG_STATUS)) begin
      rd_data = {seq, 14'd0, done, busy};
    end else if (rd_word == AW'(REG_OVF)) begin
      rd_data = 32'(ovf);
    end else begin
      rd_hit = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (rd_word == AW'(REG_RESULT0 + 4 * i)) begin
          rd_data = 32'(result[i]);
          rd_hit  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      S_AXI_ARREADY <= ar_go;
      if (rd_en) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_data;
        S_AXI_RRESP  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

endmodule
